// File: rtl/se_sram_srw_master_pkg.sv
// se_sram_srw_master_pkg: shared sizing helpers for the SRAM master slice
package se_sram_srw_master_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int ptr_width(input int depth);
    return depth > 1 ? clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/se_sram_srw_master_rsp_fifo.sv
// se_sram_srw_master_rsp_fifo: in-order read response fifo, output holds last popped value when empty
module se_sram_srw_master_rsp_fifo
  import se_sram_srw_master_pkg::*;
#(
  parameter int DW = 8,
  parameter int DEPTH = 3,
  parameter int CW = clog2(DEPTH + 1)
) (
  input  logic          sram_clock,
  input  logic          sram_clock__enable,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [CW-1:0] count
);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [DW-1:0] last;
  assign valid = count != '0;
  assign data = valid ? mem[rd_ptr] : last;
  always_ff @(posedge sram_clock)
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      last <= '0;
    end else if (sram_clock__enable) begin
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
        last <= mem[rd_ptr];
      end
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge sram_clock)
    if (sram_clock__enable && push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/se_sram_srw_master.sv
// se_sram_srw_master: credit-gated request issue to a single-port SRAM with in-order read responses
module se_sram_srw_master
  import se_sram_srw_master_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int RSP_DEPTH = 3
) (
  input  logic                     sram_clock,
  input  logic                     sram_clock__enable,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_read_not_write,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_write_data,
  output logic                     sram_select,
  output logic                     sram_read_not_write,
  output logic                     sram_write_enable,
  output logic [ADDRESS_WIDTH-1:0] sram_address,
  output logic [DATA_WIDTH-1:0]    sram_write_data,
  input  logic [DATA_WIDTH-1:0]    sram_data_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data
);
  localparam int CW = clog2(RSP_DEPTH + 1);
  localparam logic [CW:0] FULL = (CW + 1)'(RSP_DEPTH);
  logic          read_pending;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   used;
  logic          accept;
  // Credit uses registered occupancy only, so rsp_ready never reaches req_ready.
  assign used = {1'b0, fifo_count} + (CW + 1)'(read_pending);
  assign req_ready = sram_clock__enable && reset_n && used < FULL;
  assign accept = req_valid && req_ready;
  assign sram_select = accept;
  assign sram_read_not_write = req_read_not_write;
  assign sram_write_enable = accept && !req_read_not_write;
  assign sram_address = req_address;
  assign sram_write_data = req_write_data;
  always_ff @(posedge sram_clock)
    if (!reset_n) read_pending <= 1'b0;
    else if (sram_clock__enable) read_pending <= accept && req_read_not_write;
  se_sram_srw_master_rsp_fifo #(
    .DW(DATA_WIDTH),
    .DEPTH(RSP_DEPTH),
    .CW(CW)
  ) u_rsp_fifo (
    .sram_clock(sram_clock),
    .sram_clock__enable(sram_clock__enable),
    .reset_n(reset_n),
    .push(read_pending),
    .push_data(sram_data_out),
    .pop(rsp_valid && rsp_ready && sram_clock__enable),
    .valid(rsp_valid),
    .data(rsp_data),
    .count(fifo_count)
  );
  always_ff @(posedge sram_clock)
    if (reset_n) assert (used <= FULL);
endmodule

// File: tb/tb_se_sram_srw_master.sv
// tb_se_sram_srw_master: scoreboard bench for the master driving a behavioural 128x8 SRAM
module tb_se_sram_srw_master;
  logic       sram_clock = 1'b0;
  logic       en = 1'b1;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rnw = 1'b0;
  logic [6:0] req_address = '0;
  logic [7:0] req_wd = '0;
  logic       rsp_ready = 1'b1;
  logic       req_ready, sel, srnw, swe, rsp_valid;
  logic [6:0] saddr;
  logic [7:0] swd, sram_data_out, rsp_data;
  logic [7:0] mem [128];
  logic [7:0] shadow [128];
  logic [7:0] q [$];
  int vectors = 0;
  int miscompares = 0;
  bit got_accept;

  always #5 sram_clock = ~sram_clock;

  se_sram_srw_master #(.ADDRESS_WIDTH(7), .DATA_WIDTH(8), .RSP_DEPTH(3)) dut (
    .sram_clock(sram_clock),
    .sram_clock__enable(en),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_read_not_write(req_rnw),
    .req_address(req_address),
    .req_write_data(req_wd),
    .sram_select(sel),
    .sram_read_not_write(srnw),
    .sram_write_enable(swe),
    .sram_address(saddr),
    .sram_write_data(swd),
    .sram_data_out(sram_data_out),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data)
  );

  always @(posedge sram_clock)
    if (en && sel) begin
      if (!srnw && swe) mem[saddr] <= swd;
      else if (srnw) sram_data_out <= mem[saddr];
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge sram_clock)
    if (!reset_n) q.delete();
    else begin
      if (rsp_valid && rsp_ready && en) begin
        if (q.size() == 0) check("spurious_rsp", 32'(rsp_valid), 0);
        else check("rsp_data", 32'(rsp_data), 32'(q.pop_front()));
      end
      if (req_valid && req_ready) begin
        if (req_rnw) q.push_back(shadow[req_address]);
        else shadow[req_address] = req_wd;
      end
    end

  task automatic cyc();
    @(posedge sram_clock);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_rnw = 1'b0;
    req_address = a;
    req_wd = d;
    @(negedge sram_clock);
    check("wr_ready", 32'(req_ready), 1);
    check("wr_we", 32'(swe), 1);
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a);
    req_valid = 1'b1;
    req_rnw = 1'b1;
    req_address = a;
    @(negedge sram_clock);
    check("rd_ready", 32'(req_ready), 1);
    check("rd_sel", 32'({sel, swe}), 2'b10);
    cyc();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc();
    @(negedge sram_clock);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_data", 32'(rsp_data), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_sel", 32'(sel), 0);
    cyc();
    reset_n = 1'b1;
    // 1: write then read, two-cycle latency
    wr(7'h10, 8'hA5);
    rd(7'h10);
    @(negedge sram_clock);
    check("t1_lat1", 32'(rsp_valid), 0);
    cyc();
    @(negedge sram_clock);
    check("t1_lat2", 32'(rsp_valid), 1);
    check("t1_data", 32'(rsp_data), 32'hA5);
    cyc();
    // 2: back-to-back reads at full rate
    for (int i = 0; i < 5; i++) wr(7'(i), 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 4; i++) rd(7'(i));
    idle(4);
    // 3: back-pressure limits outstanding reads to three
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) rd(7'(i));
    req_valid = 1'b1;
    req_rnw = 1'b1;
    req_address = 7'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge sram_clock);
      check("t3_full", 32'(req_ready), 0);
      cyc();
    end
    rsp_ready = 1'b1;
    got_accept = 1'b0;
    for (int i = 0; i < 10 && !got_accept; i++) begin
      @(negedge sram_clock);
      got_accept = req_ready;
      cyc();
    end
    check("t3_accept", 32'(got_accept), 1);
    req_valid = 1'b0;
    rd(7'd4);
    idle(6);
    check("t3_drained", q.size(), 0);
    // 4: read immediately after write to same address
    wr(7'h20, 8'h5A);
    rd(7'h20);
    idle(4);
    // 5: clock enable low freezes everything
    rsp_ready = 1'b0;
    rd(7'd0);
    rd(7'd1);
    idle(2);
    en = 1'b0;
    req_valid = 1'b1;
    req_rnw = 1'b1;
    req_address = 7'd2;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sram_clock);
      check("t5_sel", 32'(sel), 0);
      check("t5_ready", 32'(req_ready), 0);
      check("t5_valid", 32'(rsp_valid), 1);
      cyc();
    end
    en = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge sram_clock);
    check("t5_head", 32'(rsp_data), 32'h11);
    check("t5_credit", 32'(req_ready), 1);
    cyc();
    rsp_ready = 1'b1;
    idle(4);
    check("t5_drained", q.size(), 0);
    // 6: reset with a read pending and two entries queued
    rsp_ready = 1'b0;
    rd(7'd0);
    rd(7'd1);
    rd(7'd2);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge sram_clock);
    check("t6_ready", 32'(req_ready), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge sram_clock);
      check("t6_stale", 32'(rsp_valid), 0);
      cyc();
    end
    rd(7'h10);
    idle(4);
    check("final_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
